// File: rtl/cover_gen_pkg.sv
// Shared types and constants for the cover generator.
// The optional checker is enabled with the COVER_GEN_CHECK_EN macro.
package cover_gen_pkg;

    localparam int COVER_WIDTH = 6;
    localparam logic [COVER_WIDTH-1:0] ALL_ONES = {COVER_WIDTH{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/cover_check.sv
// Combinational cover test: ok is high when value contains every bit of mask.
// Instantiated by cover_generator only when COVER_GEN_CHECK_EN is defined.
module cover_check
    import cover_gen_pkg::*;
#(
    parameter int WIDTH = COVER_WIDTH
) (
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] value,
    output logic             ok
);

    assign ok = &(~mask | value);

endmodule

// File: rtl/cover_generator.sv
// Enumerates every superset of a latched mask in ascending order over a valid/ready port.
// Defining COVER_GEN_CHECK_EN adds a sticky cover_err output fed by cover_check.
module cover_generator
    import cover_gen_pkg::*;
#(
    parameter int WIDTH = COVER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] ain,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin,
    output logic             last,
    output logic [WIDTH:0]   count,
    output logic             done
`ifdef COVER_GEN_CHECK_EN
    ,
    output logic             cover_err
`endif
);

    localparam logic [WIDTH-1:0] ONES_C    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] INC_C     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   CNT_INC_C = {{WIDTH{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             last_q, last_d;
    logic [WIDTH:0]   count_q, count_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] next_val_s;
    logic             hs_s;

    assign hs_s = valid_q & out_ready;
    // Forcing the mask bits after the increment skips every non-superset in one step.
    assign next_val_s = (bin_q + INC_C) | mask_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        bin_d   = bin_q;
        last_d  = last_q;
        count_d = count_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EMIT;
                    mask_d  = ain;
                    bin_d   = ain;
                    last_d  = (ain == ONES_C);
                    count_d = {(WIDTH+1){1'b0}};
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            EMIT: begin
                if (hs_s) begin
                    count_d = count_q + CNT_INC_C;
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        bin_d  = next_val_s;
                        last_d = (next_val_s == ONES_C);
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= {WIDTH{1'b0}};
            bin_q   <= {WIDTH{1'b0}};
            last_q  <= 1'b0;
            count_q <= {(WIDTH+1){1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            bin_q   <= bin_d;
            last_q  <= last_d;
            count_q <= count_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign bin       = bin_q;
    assign last      = last_q;
    assign count     = count_q;
    assign done      = done_q;

`ifdef COVER_GEN_CHECK_EN
    logic             ok_s;
    logic             err_q;
    logic             have_prev_q;
    logic [WIDTH-1:0] prev_q;

    cover_check #(.WIDTH(WIDTH)) u_cover_check (
        .mask  (mask_q),
        .value (bin_q),
        .ok    (ok_s)
    );

    // Sticky error: non-cover or non-increasing value seen on a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q       <= 1'b0;
            have_prev_q <= 1'b0;
            prev_q      <= {WIDTH{1'b0}};
        end else if ((state_q == IDLE) && start) begin
            err_q       <= 1'b0;
            have_prev_q <= 1'b0;
        end else if (hs_s) begin
            if (!ok_s || (have_prev_q && (bin_q <= prev_q))) begin
                err_q <= 1'b1;
            end
            prev_q      <= bin_q;
            have_prev_q <= 1'b1;
        end
    end

    assign cover_err = err_q;
`endif

endmodule

// File: doc/cover_generator.md
Name: cover_generator

Overview:
- Sequential producer of covers: given a WIDTH-bit required mask ain, emits every WIDTH-bit value bin with (ain & ~bin) == 0, i.e. every superset of ain.
- Emits one value per accepted handshake, in ascending numeric order, from ain up to all-ones.
- Feeds the existing cover-detection logic and test harnesses with exhaustive legal stimulus.

Parameters:
- WIDTH, 6, bit width of mask and generated values.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  request a new enumeration; sampled only in IDLE
- ain  input  WIDTH  required mask; latched on accepted start
- busy  output  1  high while state is EMIT
- out_valid  output  1  bin holds a valid cover
- out_ready  input  1  consumer accepts bin this cycle
- bin  output  WIDTH  current cover value
- last  output  1  qualifies bin as final cover (bin == all-ones)
- count  output  WIDTH+1  number of covers accepted in current/last run
- done  output  1  one-cycle pulse after final handshake

Behaviour:
- Interface fixed: one clock clk; reset is synchronous and active-high.
- Reset values: busy=0, out_valid=0, bin=0, last=0, count=0, done=0, state=IDLE, mask register=0.
- Reset has priority over all other inputs. Mid-run reset aborts on the next edge: no further outputs and no done pulse.
- All outputs are registered. Latency is one cycle: start accepted at edge N gives out_valid=1 and bin=ain after edge N.
- FSM state IDLE:
  - start=1 latches mask<=ain, cur<=ain, count<=0, and moves to EMIT.
  - start=0 holds state.
- FSM state EMIT:
  - out_valid=1, bin=cur, last=(cur=={WIDTH{1'b1}}).
  - On handshake (out_valid & out_ready), count<=count+1.
  - If last, the FSM also moves to IDLE and pulses done for one cycle. Otherwise cur<=(cur+1)|mask, truncated to WIDTH.
- Stall: while out_valid & ~out_ready, bin, last and count are held stable.
- start is ignored while busy. A start that coincides with the final handshake is ignored; a new run needs start while in IDLE.
- ain changes after acceptance have no effect on the current run.
- count after a run equals 2^(WIDTH-popcount(ain)). count is WIDTH+1 bits so it can hold 2^WIDTH without wrap. count holds its value in IDLE until the next accepted start.
- Boundary cases:
  - ain all-ones: exactly one output, with last=1.
  - ain=0: 2^WIDTH outputs, 0 through all-ones.
- The sequence is strictly increasing, so the increment never wraps before last.

Optional Feature:
- Macro: COVER_GEN_CHECK_EN.
- Defined:
  - Adds output port cover_err (1 bit, reset 0).
  - cover_err is a sticky flag, set on any handshake where (mask & ~bin) != 0 or where bin does not exceed the previous emitted value.
  - Cleared only by reset or by an accepted start.
- Undefined: port and checker logic are absent; functional behaviour is otherwise identical.

Decomposition:
- Package cover_gen_pkg:
  - COVER_WIDTH constant (default 6).
  - State typedef state_t {IDLE, EMIT}.
  - ALL_ONES constant.
- Natural sub-module: cover_check. Combinational; inputs mask and value; output ok = &(~mask | value). Instantiated only under COVER_GEN_CHECK_EN.

Test Plan:
- ain=110000, out_ready=1, start pulse -> 16 outputs: 110000,110001,110010,...,111111. last only on 111111. count=16. done pulses once the cycle after the last handshake.
- ain=111111 -> single output 111111 with last=1, count=1, busy high for exactly one cycle.
- ain=000000 -> 64 outputs 000000..111111 ascending. count=64 (7'b1000000) with no wrap.
- ain=000010, out_ready toggling 1,0,0,1... -> sequence 000010,000011,000110,000111,001010... Each value is held stable across stall cycles and no value is skipped or repeated.
- ain=000010, reset asserted after 3 handshakes -> next cycle out_valid=0, busy=0, count=0, no done pulse. A start during EMIT in a separate run is ignored and count continues.
- With COVER_GEN_CHECK_EN defined: sweep all 64 ain values, each run to completion -> cover_err stays 0. Per-run count matches 2^(6-popcount(ain)).
